// File: rtl/ucode_sequencer.sv
// Microcode sequencer: a writable control store, a program counter with jump,
// conditional branch and counted-loop support, and a ready/valid instruction port.
module ucode_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [ADDR_W-1:0]  start_addr_i,
  input  logic               cond_i,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef enum logic [2:0] {
    OP_END  = 3'b000,
    OP_NEXT = 3'b001,
    OP_JMP  = 3'b010,
    OP_BRC  = 3'b011,
    OP_LDC  = 3'b100,
    OP_LOOP = 3'b101
  } op_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc, fetch_addr, tgt;
  logic [7:0]          cnt_q, cnt_d;
  logic [INSTR_W-1:0]  instr_q, fetch_data;
  logic                err_q, err_set, err_clr;
  logic                fetch, take, adv, wr_ok, start_ok, tgt_ok;
  op_t                 op;

  logic [INSTR_W-1:0]  mem [DEPTH];

  assign op       = op_t'(instr_q[INSTR_W-1 -: 3]);
  assign tgt      = instr_q[ADDR_W-1:0];
  assign pc_inc   = (pc_q == LAST_C) ? '0 : pc_q + 1'b1;
  assign start_ok = {1'b0, start_addr_i} < DEPTH_C;
  assign tgt_ok   = {1'b0, tgt} < DEPTH_C;
  assign wr_ok    = (state_q == S_IDLE) && wr_en_i && ({1'b0, wr_addr_i} < DEPTH_C);

  // A write landing in the same cycle as the start is forwarded to the first fetch.
  assign fetch_data = (wr_ok && (wr_addr_i == fetch_addr)) ? wr_data_i : mem[fetch_addr];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    fetch      = 1'b0;
    fetch_addr = pc_q;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    take       = 1'b0;
    adv        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            state_d    = S_RUN;
            pc_d       = start_addr_i;
            fetch      = 1'b1;
            fetch_addr = start_addr_i;
            err_clr    = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (instr_ready_i) begin
          case (op)
            OP_END:  state_d = S_DONE;
            OP_JMP:  take = 1'b1;
            OP_BRC:  if (cond_i) take = 1'b1; else adv = 1'b1;
            OP_LDC:  begin cnt_d = instr_q[ADDR_W+7:ADDR_W]; adv = 1'b1; end
            OP_LOOP: begin
              if (cnt_q != 8'd0) begin
                take  = 1'b1;
                cnt_d = cnt_q - 8'd1;
              end else begin
                adv = 1'b1;
              end
            end
            default: adv = 1'b1;
          endcase
          if (take) begin
            if (tgt_ok) begin
              pc_d       = tgt;
              fetch      = 1'b1;
              fetch_addr = tgt;
            end else begin
              err_set = 1'b1;
              state_d = S_IDLE;
            end
          end
          if (adv) begin
            pc_d       = pc_inc;
            fetch      = 1'b1;
            fetch_addr = pc_inc;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      if (fetch)        instr_q <= fetch_data;
      if (err_set)      err_q   <= 1'b1;
      else if (err_clr) err_q   <= 1'b0;
    end
  end

  // NOTE: the control store has no reset so it maps onto plain RAM and survives rst_ni.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_addr_i] <= wr_data_i;
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = (state_q == S_RUN);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: an instruction-level reference
// interpreter is compared against the DUT every cycle, plus directed literal checks.
module tb_ucode_sequencer;

  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 12;
  localparam int INSTR_W = 32;

  logic               clk, rst_ni;
  logic               start_i, cond_i, wr_en_i, instr_ready_i;
  logic [ADDR_W-1:0]  start_addr_i, wr_addr_i;
  logic [INSTR_W-1:0] wr_data_i, instr_o;
  logic               instr_valid_o, busy_o, done_o, err_o;

  ucode_sequencer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .INSTR_W(INSTR_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .start_addr_i(start_addr_i),
    .cond_i(cond_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  bit cmp_en  = 1'b0;
  int e[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference interpreter: program state at instruction granularity.
  typedef struct {
    bit running;
    bit done;
    bit err;
    int pc;
    int cnt;
  } mstate_t;

  mstate_t     m;
  logic [31:0] m_mem [DEPTH];
  int          m_trace[$];

  function automatic mstate_t jump_to(input mstate_t s, input int t);
    mstate_t n = s;
    if (t >= DEPTH) begin
      n.err     = 1'b1;
      n.running = 1'b0;
    end else begin
      n.pc = t;
    end
    return n;
  endfunction

  function automatic mstate_t model_next(input mstate_t s);
    mstate_t     n = s;
    logic [31:0] w;
    int          seq;
    if (s.done) begin
      n.done = 1'b0;
    end else if (!s.running) begin
      if (start_i) begin
        if (int'(start_addr_i) < DEPTH) begin
          n.running = 1'b1;
          n.pc      = int'(start_addr_i);
          n.err     = 1'b0;
        end else begin
          n.err = 1'b1;
        end
      end
    end else if (instr_ready_i) begin
      w   = m_mem[s.pc];
      seq = (s.pc + 1) % DEPTH;
      case (w[31:29])
        3'd0: begin n.running = 1'b0; n.done = 1'b1; end
        3'd2: n = jump_to(n, int'(w[3:0]));
        3'd3: if (cond_i) n = jump_to(n, int'(w[3:0])); else n.pc = seq;
        3'd4: begin n.cnt = int'(w[11:4]); n.pc = seq; end
        3'd5: begin
          if (s.cnt != 0) begin
            n.cnt = s.cnt - 1;
            n = jump_to(n, int'(w[3:0]));
          end else begin
            n.pc = seq;
          end
        end
        default: n.pc = seq;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m <= '{default: 0};
    end else begin
      if (!m.running && !m.done && wr_en_i && int'(wr_addr_i) < DEPTH)
        m_mem[wr_addr_i] <= wr_data_i;
      if (m.running && instr_ready_i) m_trace.push_back(m.pc);
      m <= model_next(m);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",  32'(busy_o),        32'(m.running | m.done));
      check("valid", 32'(instr_valid_o), 32'(m.running));
      check("done",  32'(done_o),        32'(m.done));
      check("err",   32'(err_o),         32'(m.err));
      if (m.running) check("instr", instr_o, m_mem[m.pc]);
    end
  end

  always @(negedge clk) if (done_o) n_done++;

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [7:0] cnt, input logic [3:0] tgt);
    return {op, 17'd0, cnt, tgt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = ADDR_W'(a);
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic start(input int a);
    start_i      = 1'b1;
    start_addr_i = ADDR_W'(a);
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy_o && k < budget) begin
      tick();
      k++;
    end
    check({name, " timeout"}, 32'(busy_o), 32'd0);
  endtask

  task automatic check_trace(input string name, input int exp[$]);
    check({name, " beats"}, 32'(m_trace.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      if (i < m_trace.size()) check({name, " pc"}, 32'(m_trace[i]), 32'(exp[i]));
  endtask

  task automatic load_loop();
    wr(0, mk(3'd4, 8'd3, 4'd0));
    wr(1, mk(3'd1, 8'd0, 4'd0));
    wr(2, mk(3'd5, 8'd0, 4'd1));
    wr(3, mk(3'd0, 8'd0, 4'd0));
  endtask

  initial begin
    int d0;
    rst_ni = 1'b0; start_i = 1'b0; start_addr_i = '0; cond_i = 1'b0;
    wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0; instr_ready_i = 1'b1;
    tick();
    check("rst busy",  32'(busy_o), 32'd0);
    check("rst valid", 32'(instr_valid_o), 32'd0);
    check("rst done",  32'(done_o), 32'd0);
    check("rst err",   32'(err_o), 32'd0);
    check("rst instr", instr_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    cmp_en = 1'b1;
    for (int i = 0; i < DEPTH; i++)
      wr(i, mk((i % 2 == 0) ? 3'd1 : 3'd6, 8'(i * 17), 4'(i)));

    // straight-line program
    wr(0, mk(3'd1, 8'd0, 4'd0)); wr(1, mk(3'd1, 8'd1, 4'd0)); wr(2, mk(3'd0, 8'd0, 4'd0));
    m_trace.delete(); d0 = n_done;
    start(0); wait_idle("seq", 50);
    e = '{0, 1, 2}; check_trace("seq", e);
    check("seq done pulses", 32'(n_done - d0), 32'd1);

    // counted loop
    load_loop();
    m_trace.delete();
    start(0); wait_idle("loop", 100);
    e = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 3}; check_trace("loop", e);

    // conditional branch taken / not taken
    wr(0, mk(3'd3, 8'd0, 4'd5)); wr(5, mk(3'd0, 8'd0, 4'd0));
    cond_i = 1'b1; m_trace.delete();
    start(0); wait_idle("brc1", 50);
    e = '{0, 5}; check_trace("brc1", e);
    wr(1, mk(3'd0, 8'd0, 4'd0));
    cond_i = 1'b0; m_trace.delete();
    start(0); wait_idle("brc0", 50);
    e = '{0, 1}; check_trace("brc0", e);

    // backpressure stall
    wr(0, mk(3'd1, 8'hA5, 4'd0));
    instr_ready_i = 1'b0; m_trace.delete();
    start(0);
    repeat (4) tick();
    check("stall instr", instr_o, 32'h2000_0A50);
    check("stall valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    wait_idle("stall", 50);
    e = '{0, 1}; check_trace("stall", e);

    // bad jump target, with a dropped write while running
    wr(0, mk(3'd1, 8'd0, 4'd0)); wr(1, mk(3'd2, 8'd0, 4'd13));
    instr_ready_i = 1'b0; m_trace.delete(); d0 = n_done;
    start(0);
    wr(1, mk(3'd0, 8'd0, 4'd0));
    instr_ready_i = 1'b1;
    wait_idle("badjmp", 50);
    e = '{0, 1}; check_trace("badjmp", e);
    check("badjmp err", 32'(err_o), 32'd1);
    check("badjmp no done", 32'(n_done - d0), 32'd0);

    // out-of-range start address
    start(12);
    check("badstart busy", 32'(busy_o), 32'd0);
    check("badstart err", 32'(err_o), 32'd1);

    // write and start in the same cycle; accepted start clears err
    wr_en_i = 1'b1; wr_addr_i = 4'd4; wr_data_i = mk(3'd0, 8'd0, 4'd0);
    m_trace.delete();
    start(4);
    wr_en_i = 1'b0;
    wait_idle("fwd", 50);
    e = '{4}; check_trace("fwd", e);
    check("fwd err cleared", 32'(err_o), 32'd0);

    // pc wraps from DEPTH-1 to 0
    wr(11, mk(3'd7, 8'd0, 4'd0)); wr(0, mk(3'd0, 8'd0, 4'd0));
    m_trace.delete();
    start(11); wait_idle("wrap", 50);
    e = '{11, 0}; check_trace("wrap", e);

    // reset in the middle of a loop, then replay
    load_loop();
    d0 = n_done;
    start(0);
    repeat (3) tick();
    #1 rst_ni = 1'b0;
    #1;
    check("midrst busy",  32'(busy_o), 32'd0);
    check("midrst valid", 32'(instr_valid_o), 32'd0);
    check("midrst instr", instr_o, 32'd0);
    check("midrst done",  32'(done_o), 32'd0);
    tick(); tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    check("midrst no resume", 32'(busy_o), 32'd0);
    check("midrst no done", 32'(n_done - d0), 32'd0);
    m_trace.delete();
    start(0); wait_idle("replay", 100);
    e = '{0, 1, 2, 1, 2, 1, 2, 1, 2, 3}; check_trace("replay", e);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
